// File: rtl/snake_body_ctrl_pkg.sv
// Shared definitions for the snake body controller: grid defaults, coordinate type,
// direction and FSM state codes, initial snake placement.
package snake_body_ctrl_pkg;

  localparam int COORD_W      = 6;
  localparam int SIZE_W       = 12;
  localparam int XSIZE_DEF    = 48;
  localparam int YSIZE_DEF    = 64;
  localparam int MAX_SIZE_DEF = 20;
  localparam int INIT_X       = 24;
  localparam int INIT_Y       = 32;
  localparam int INIT_LEN     = 3;

  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_RIGHT = 2'b11
  } dir_t;

  typedef enum logic [1:0] {
    ST_INIT = 2'b00,
    ST_REQ  = 2'b01,
    ST_RUN  = 2'b10,
    ST_OVER = 2'b11
  } state_t;

  // Opposite directions differ only in bit 0 (up/down, left/right).
  function automatic dir_t reverse_dir(input dir_t d);
    return dir_t'(d ^ 2'b01);
  endfunction

endpackage

// File: rtl/snake_body_ctrl_next_head.sv
// Combinational head stepper: current head + direction -> next head and wall flag.
// Build option WRAP_WALLS_EN: edges wrap around instead of raising the wall flag.
module snake_body_ctrl_next_head
  import snake_body_ctrl_pkg::*;
#(
  parameter int XSIZE = XSIZE_DEF,
  parameter int YSIZE = YSIZE_DEF
) (
  input  coord_t head_x,
  input  coord_t head_y,
  input  dir_t   dir,
  output coord_t next_x,
  output coord_t next_y,
  output logic   wall_hit
);

  localparam coord_t X_MAX = coord_t'(XSIZE - 1);
  localparam coord_t Y_MAX = coord_t'(YSIZE - 1);
  localparam coord_t ONE   = coord_t'(1);

  always_comb begin
    next_x   = head_x;
    next_y   = head_y;
    wall_hit = 1'b0;
    unique case (dir)
      DIR_UP: begin
        if (head_y == '0) begin
`ifdef WRAP_WALLS_EN
          next_y = Y_MAX;
`else
          wall_hit = 1'b1;
`endif
        end else begin
          next_y = head_y - ONE;
        end
      end
      DIR_DOWN: begin
        if (head_y == Y_MAX) begin
`ifdef WRAP_WALLS_EN
          next_y = '0;
`else
          wall_hit = 1'b1;
`endif
        end else begin
          next_y = head_y + ONE;
        end
      end
      DIR_LEFT: begin
        if (head_x == '0) begin
`ifdef WRAP_WALLS_EN
          next_x = X_MAX;
`else
          wall_hit = 1'b1;
`endif
        end else begin
          next_x = head_x - ONE;
        end
      end
      DIR_RIGHT: begin
        // x wraps at XSIZE-1 by explicit compare, not 6-bit overflow
        if (head_x == X_MAX) begin
`ifdef WRAP_WALLS_EN
          next_x = '0;
`else
          wall_hit = 1'b1;
`endif
        end else begin
          next_x = head_x + ONE;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/snake_body_ctrl.sv
// Snake body owner: moves/grows the body on move ticks, requests items, flags collisions.
// Build option WRAP_WALLS_EN (in snake_body_ctrl_next_head) turns walls into wrap-around edges.
module snake_body_ctrl
  import snake_body_ctrl_pkg::*;
#(
  parameter int XSIZE    = XSIZE_DEF,
  parameter int YSIZE    = YSIZE_DEF,
  parameter int MAX_SIZE = MAX_SIZE_DEF
) (
  input  logic                          i_Clk,
  input  logic                          i_Rst,
  input  logic                          i_Move_tick,
  input  logic [1:0]                    i_Dir,
  input  logic [COORD_W-1:0]            i_Item_x,
  input  logic [COORD_W-1:0]            i_Item_y,
  input  logic                          i_isMakeItem_Done,
  output logic                          o_ItemNeed,
  output logic [MAX_SIZE*COORD_W-1:0]   o_Body_x,
  output logic [MAX_SIZE*COORD_W-1:0]   o_Body_y,
  output logic [SIZE_W-1:0]             o_Body_size,
  output logic                          o_GameOver,
  output state_t                        o_Dbg_state
);

  // Item handshake: o_ItemNeed is a level held while in REQ; the generator answers with a
  // single-cycle i_isMakeItem_Done carrying a valid item, which is latched on that edge.

  state_t            state_q, state_d;
  dir_t              dir_q, eff_dir;
  coord_t            seg_x_q [MAX_SIZE];
  coord_t            seg_y_q [MAX_SIZE];
  logic [SIZE_W-1:0] size_q;
  coord_t            item_x_q, item_y_q;
  coord_t            next_x, next_y;
  logic              wall_hit, eat, self_hit, tick_run;

  snake_body_ctrl_next_head #(
    .XSIZE (XSIZE),
    .YSIZE (YSIZE)
  ) u_next_head (
    .head_x   (seg_x_q[0]),
    .head_y   (seg_y_q[0]),
    .dir      (eff_dir),
    .next_x   (next_x),
    .next_y   (next_y),
    .wall_hit (wall_hit)
  );

  // The tail cell is vacated by a plain move, so it only counts as an obstacle when eating.
  always_comb begin
    eff_dir  = (dir_t'(i_Dir) == reverse_dir(dir_q)) ? dir_q : dir_t'(i_Dir);
    eat      = (next_x == item_x_q) && (next_y == item_y_q);
    tick_run = (state_q == ST_RUN) && i_Move_tick;
    self_hit = 1'b0;
    for (int i = 0; i < MAX_SIZE; i++) begin
      if (((i < int'(size_q) - 1) || (eat && (i < int'(size_q)))) &&
          (seg_x_q[i] == next_x) && (seg_y_q[i] == next_y)) begin
        self_hit = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_INIT: state_d = ST_REQ;
      ST_REQ:  if (i_isMakeItem_Done) state_d = ST_RUN;
      ST_RUN: begin
        if (i_Move_tick) begin
          if (wall_hit || self_hit) state_d = ST_OVER;
          else if (eat)             state_d = ST_REQ;
        end
      end
      ST_OVER: state_d = ST_OVER;
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) state_q <= ST_INIT;
    else       state_q <= state_d;
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      dir_q    <= DIR_UP;
      size_q   <= SIZE_W'(INIT_LEN);
      item_x_q <= '0;
      item_y_q <= '0;
      for (int i = 0; i < MAX_SIZE; i++) begin
        if (i < INIT_LEN) begin
          seg_x_q[i] <= coord_t'(INIT_X);
          seg_y_q[i] <= coord_t'(INIT_Y + i);
        end else begin
          seg_x_q[i] <= '0;
          seg_y_q[i] <= '0;
        end
      end
    end else begin
      if ((state_q == ST_REQ) && i_isMakeItem_Done) begin
        item_x_q <= i_Item_x;
        item_y_q <= i_Item_y;
      end
      if (tick_run) begin
        dir_q <= eff_dir;
        if (!wall_hit && !self_hit) begin
          for (int i = MAX_SIZE - 1; i > 0; i--) begin
            seg_x_q[i] <= seg_x_q[i-1];
            seg_y_q[i] <= seg_y_q[i-1];
          end
          seg_x_q[0] <= next_x;
          seg_y_q[0] <= next_y;
          if (eat && (size_q < SIZE_W'(MAX_SIZE))) size_q <= size_q + 1'b1;
        end
      end
    end
  end

  always_comb begin
    o_Body_x = '0;
    o_Body_y = '0;
    for (int i = 0; i < MAX_SIZE; i++) begin
      o_Body_x[i*COORD_W +: COORD_W] = seg_x_q[i];
      o_Body_y[i*COORD_W +: COORD_W] = seg_y_q[i];
    end
  end

  assign o_ItemNeed  = (state_q == ST_REQ);
  assign o_GameOver  = (state_q == ST_OVER);
  assign o_Body_size = size_q;
  assign o_Dbg_state = state_q;

endmodule

// File: tb/tb_snake_body_ctrl.sv
// Self-checking bench for snake_body_ctrl: directed table, hand sequences, and random play
// against a queue-based model of the snake.
module tb_snake_body_ctrl;

  import snake_body_ctrl_pkg::*;

  localparam int MAXS = 20;
  localparam int XS   = 48;
  localparam int YS   = 64;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             tick = 1'b0;
  logic [1:0]       dir = 2'b00;
  logic [5:0]       ix = '0, iy = '0;
  logic             done = 1'b0;
  logic             need, over;
  logic [MAXS*6-1:0] bx, by;
  logic [11:0]      bsize;
  state_t           dbg_state;

  snake_body_ctrl dut (
    .i_Clk             (clk),
    .i_Rst             (rst),
    .i_Move_tick       (tick),
    .i_Dir             (dir),
    .i_Item_x          (ix),
    .i_Item_y          (iy),
    .i_isMakeItem_Done (done),
    .o_ItemNeed        (need),
    .o_Body_x          (bx),
    .o_Body_y          (by),
    .o_Body_size       (bsize),
    .o_GameOver        (over),
    .o_Dbg_state       (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  function automatic int sx(input int i);
    return int'(bx[i*6 +: 6]);
  endfunction
  function automatic int sy(input int i);
    return int'(by[i*6 +: 6]);
  endfunction

  // ---------------- reference model ----------------
  int mx[$], my[$];
  int m_dir, m_need, m_over, m_init, m_ix, m_iy;

  function automatic int ddx(input int d);
    return (d == 2) ? -1 : (d == 3) ? 1 : 0;
  endfunction
  function automatic int ddy(input int d);
    return (d == 0) ? -1 : (d == 1) ? 1 : 0;
  endfunction

  task automatic model_reset();
    mx = '{24, 24, 24};
    my = '{32, 33, 34};
    m_dir = 0; m_need = 0; m_over = 0; m_init = 1; m_ix = 0; m_iy = 0;
  endtask

  task automatic model_step(input int t, input int d, input int dn, input int x, input int y);
    int nx, ny, lim;
    bit hit, eat;
    if (m_over != 0) return;
    if (m_init != 0) begin m_init = 0; m_need = 1; return; end
    if (m_need != 0) begin
      if (dn != 0) begin m_ix = x; m_iy = y; m_need = 0; end
      return;
    end
    if (t == 0) return;
    if (!((ddx(d) + ddx(m_dir) == 0) && (ddy(d) + ddy(m_dir) == 0))) m_dir = d;
    nx = mx[0] + ddx(m_dir);
    ny = my[0] + ddy(m_dir);
`ifdef WRAP_WALLS_EN
    if (nx < 0) nx = XS - 1;
    if (nx >= XS) nx = 0;
    if (ny < 0) ny = YS - 1;
    if (ny >= YS) ny = 0;
`else
    if (nx < 0 || nx >= XS || ny < 0 || ny >= YS) begin m_over = 1; return; end
`endif
    eat = (nx == m_ix) && (ny == m_iy);
    lim = eat ? mx.size() : mx.size() - 1;
    hit = 1'b0;
    for (int i = 0; i < lim; i++) if (mx[i] == nx && my[i] == ny) hit = 1'b1;
    if (hit) begin m_over = 1; return; end
    mx.push_front(nx);
    my.push_front(ny);
    if (!eat || mx.size() > MAXS) begin
      void'(mx.pop_back());
      void'(my.pop_back());
    end
    if (eat) m_need = 1;
  endtask

  task automatic compare_model(input string tag);
    int bad;
    chk({tag, "_size"}, int'(bsize), mx.size());
    chk({tag, "_need"}, int'(need), m_need);
    chk({tag, "_over"}, int'(over), m_over);
    bad = 0;
    for (int i = 0; i < mx.size(); i++) if (sx(i) != mx[i] || sy(i) != my[i]) bad++;
    chk({tag, "_body_bad_segs"}, bad, 0);
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input int t, input int d, input int dn, input int x, input int y);
    tick = t[0]; dir = d[1:0]; done = dn[0]; ix = x[5:0]; iy = y[5:0];
    @(posedge clk); #1;
    tick = 1'b0; done = 1'b0;
    model_step(t, d, dn, x, y);
  endtask

  task automatic do_reset();
    rst = 1'b1; tick = 1'b0; done = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic start_game(input int x, input int y);
    do_reset();
    step(0, 0, 0, 0, 0);
    step(0, 0, 1, x, y);
  endtask

  typedef struct {
    logic [1:0] dir;
    int hx, hy, tx, ty;
  } vec_t;
  vec_t vecs[8];

  initial begin
    int nx, ny, r, d, ok;
    vecs[0] = '{2'b00, 24, 31, 24, 33};
    vecs[1] = '{2'b01, 24, 30, 24, 32};
    vecs[2] = '{2'b10, 23, 30, 24, 31};
    vecs[3] = '{2'b00, 23, 29, 24, 30};
    vecs[4] = '{2'b11, 24, 29, 23, 30};
    vecs[5] = '{2'b10, 25, 29, 23, 29};
    vecs[6] = '{2'b01, 25, 30, 24, 29};
    vecs[7] = '{2'b01, 25, 31, 25, 29};

    // Test 1: reset values, request after release, done clears request
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_need", int'(need), 0);
    chk("rst_over", int'(over), 0);
    chk("rst_size", int'(bsize), 3);
    chk("rst_seg0_x", sx(0), 24);
    chk("rst_seg0_y", sy(0), 32);
    chk("rst_seg2_y", sy(2), 34);
    chk("rst_seg3_x", sx(3), 0);
    rst = 1'b0;
    model_reset();
    step(0, 0, 0, 0, 0);
    chk("t1_need_rise", int'(need), 1);
    step(1, 2, 0, 0, 0);
    chk("t1_tick_in_req_dropped", sx(0), 24);
    step(0, 0, 1, 10, 10);
    chk("t1_need_fall", int'(need), 0);
    chk("t1_size", int'(bsize), 3);

    // Test 2: eat item directly above head
    start_game(24, 31);
    step(1, 0, 0, 0, 0);
    chk("t2_seg0_y", sy(0), 31);
    chk("t2_seg1_y", sy(1), 32);
    chk("t2_size", int'(bsize), 4);
    chk("t2_need", int'(need), 1);

    // Table: moves including ignored reversals
    start_game(10, 10);
    for (int k = 0; k < 8; k++) begin
      step(1, int'(vecs[k].dir), 0, 0, 0);
      chk($sformatf("tbl%0d_hx", k), sx(0), vecs[k].hx);
      chk($sformatf("tbl%0d_hy", k), sy(0), vecs[k].hy);
      chk($sformatf("tbl%0d_tx", k), sx(2), vecs[k].tx);
      chk($sformatf("tbl%0d_ty", k), sy(2), vecs[k].ty);
      chk($sformatf("tbl%0d_over", k), int'(over), 0);
    end

    // Test 4: top wall
    start_game(10, 10);
    for (int k = 0; k < 32; k++) step(1, 0, 0, 0, 0);
    chk("t4_head_at_top", sy(0), 0);
    step(1, 0, 0, 0, 0);
`ifdef WRAP_WALLS_EN
    chk("t4_wrap_y", sy(0), 63);
    chk("t4_wrap_over", int'(over), 0);
`else
    chk("t4_wall_over", int'(over), 1);
    chk("t4_frozen_y", sy(0), 0);
    step(1, 2, 0, 0, 0);
    chk("t4_frozen_after_tick_x", sx(0), 24);
`endif

    // Test 5: grow to 5 then curl into the body
    start_game(24, 31);
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, 24, 30);
    step(1, 0, 0, 0, 0);
    chk("t5_size5", int'(bsize), 5);
    step(0, 0, 1, 10, 10);
    step(1, 2, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    chk("t5_head_before_hit_x", sx(0), 23);
    chk("t5_head_before_hit_y", sy(0), 31);
    step(1, 3, 0, 0, 0);
    chk("t5_self_over", int'(over), 1);
    chk("t5_size_kept", int'(bsize), 5);
    chk("t5_head_frozen_x", sx(0), 23);
    chk("t5_seg1_frozen_y", sy(1), 30);

    // Test 6: async reset drops an outstanding request; done during reset is ignored
    do_reset();
    step(0, 0, 0, 0, 0);
    chk("t6_need_before", int'(need), 1);
    #2 rst = 1'b1;
    #1 chk("t6_need_async_clear", int'(need), 0);
    done = 1'b1; ix = 6'd5; iy = 6'd5;
    @(posedge clk); #1;
    done = 1'b0;
    rst = 1'b0;
    model_reset();
    step(0, 0, 0, 0, 0);
    chk("t6_need_reraised", int'(need), 1);
    step(0, 0, 0, 0, 0);
    chk("t6_still_waiting", int'(need), 1);

    // Random play against the model
    do_reset();
    step(0, 0, 0, 0, 0);
    for (int k = 0; k < 1500; k++) begin
      if (m_over != 0) begin
        do_reset();
        step(0, 0, 0, 0, 0);
      end
      r = int'($urandom_range(0, 99));
      if (m_need != 0) begin
        if (r < 75) begin
          if ($urandom_range(0, 1) == 1) begin
            nx = mx[0] + int'($urandom_range(0, 8)) - 4;
            ny = my[0] + int'($urandom_range(0, 8)) - 4;
            if (nx < 0) nx = 0;
            if (nx > XS - 1) nx = XS - 1;
            if (ny < 0) ny = 0;
            if (ny > YS - 1) ny = YS - 1;
          end else begin
            nx = int'($urandom_range(0, XS - 1));
            ny = int'($urandom_range(0, YS - 1));
          end
          step(0, 0, 1, nx, ny);
        end else begin
          step(1, int'($urandom_range(0, 3)), 0, 0, 0);
        end
      end else if (r < 15) begin
        step(0, int'($urandom_range(0, 3)), 0, 0, 0);
      end else begin
        if (r < 75) begin
          if (m_ix > mx[0])      d = 3;
          else if (m_ix < mx[0]) d = 2;
          else if (m_iy > my[0]) d = 1;
          else                   d = 0;
        end else begin
          d = int'($urandom_range(0, 3));
        end
        step(1, d, 0, 0, 0);
      end
      compare_model($sformatf("rnd%0d", k));
    end

    ok = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
